// File: rtl/keypad_row_scanner.sv
// Row-scanning keypad controller: drives a 4-to-16 active-low row decoder, debounces the
// active-low column returns and reports one key code per press over a valid/ready handshake.
module keypad_row_scanner #(
  parameter int NCOLS          = 4,
  parameter int SETTLE_CYCLES  = 4,
  parameter int DEBOUNCE_SCANS = 3,
  localparam int CW            = $clog2(NCOLS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             scan_en,
  output logic [3:0]       row_sel,
  output logic             row_en,
  input  logic [NCOLS-1:0] col_n,
  output logic             key_valid,
  input  logic             key_ready,
  output logic [3+CW:0]    key_code,
  output logic             multi_key
);

  localparam int CNT_W = $clog2(SETTLE_CYCLES + 1);
  localparam int HIT_W = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] REL_SAMPLE  = CNT_W'(SETTLE_CYCLES);
  localparam logic [HIT_W-1:0] HITS_DONE   = HIT_W'(DEBOUNCE_SCANS);
  localparam logic [HIT_W-1:0] REL_LAST    = HIT_W'(DEBOUNCE_SCANS - 1);

  typedef enum logic [2:0] {IDLE, SETTLE, SAMPLE, REPORT, RELEASE} state_t;

  // Scanner state is kept as a named enum so checkers can bind to it directly.
  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [HIT_W-1:0] hit_cnt;
  logic [HIT_W-1:0] rel_cnt;
  logic [3+CW:0]    cand;

  logic [NCOLS-1:0] col_meta;
  logic [NCOLS-1:0] col_sync;
  logic [NCOLS-1:0] col_low;
  logic [CW-1:0]    low_idx;
  logic             any_low;
  logic             multi_low;
  logic             cand_match;
  logic [3+CW:0]    sample_code;
  logic [HIT_W-1:0] next_hits;

  // Idle level of an open column is high, so the synchronizer resets to all ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_meta <= '1;
      col_sync <= '1;
    end else begin
      col_meta <= col_n;
      col_sync <= col_meta;
    end
  end

  assign col_low   = ~col_sync;
  assign any_low   = |col_low;
  assign multi_low = |(col_low & (col_low - NCOLS'(1)));

  always_comb begin
    low_idx = '0;
    for (int i = NCOLS - 1; i >= 0; i--) begin
      if (col_low[i]) low_idx = CW'(i);
    end
  end

  // The candidate always belongs to the current row (it is cleared on every row advance),
  // so a non-zero hit count plus an equal code means the same key was seen again.
  assign sample_code = {row_sel, low_idx};
  assign cand_match  = (hit_cnt != '0) && (cand == sample_code);
  assign next_hits   = cand_match ? hit_cnt + HIT_W'(1) : HIT_W'(1);

  // Handshake: key_valid rises with key_code/multi_key already stable and holds them until
  // a cycle where key_ready is also high; that cycle is the transfer and key_valid falls on
  // the following edge. key_valid never depends combinationally on key_ready.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      row_sel   <= '0;
      row_en    <= 1'b0;
      key_valid <= 1'b0;
      key_code  <= '0;
      multi_key <= 1'b0;
      cnt       <= '0;
      hit_cnt   <= '0;
      rel_cnt   <= '0;
      cand      <= '0;
    end else if (!scan_en && (state == SETTLE || state == SAMPLE || state == RELEASE)) begin
      state   <= IDLE;
      row_en  <= 1'b0;
      cnt     <= '0;
      hit_cnt <= '0;
      rel_cnt <= '0;
      cand    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (scan_en) begin
            state   <= SETTLE;
            row_sel <= '0;
            row_en  <= 1'b1;
            cnt     <= '0;
          end
        end
        SETTLE: begin
          if (cnt == SETTLE_LAST) begin
            state <= SAMPLE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        SAMPLE: begin
          if (!any_low) begin
            cand    <= '0;
            hit_cnt <= '0;
            row_sel <= row_sel + 4'd1;
            state   <= SETTLE;
          end else begin
            cand    <= sample_code;
            hit_cnt <= next_hits;
            if (next_hits == HITS_DONE) begin
              key_code  <= sample_code;
              multi_key <= multi_low;
              key_valid <= 1'b1;
              state     <= REPORT;
            end else begin
              state <= SETTLE;
            end
          end
        end
        REPORT: begin
          if (key_ready) begin
            key_valid <= 1'b0;
            if (scan_en) begin
              state   <= RELEASE;
              cnt     <= '0;
              rel_cnt <= '0;
            end else begin
              state   <= IDLE;
              row_en  <= 1'b0;
              cand    <= '0;
              hit_cnt <= '0;
            end
          end
        end
        RELEASE: begin
          // Same row period as the scan: SETTLE_CYCLES cycles of settling, then one sample.
          if (cnt != REL_SAMPLE) begin
            cnt <= cnt + CNT_W'(1);
          end else begin
            cnt <= '0;
            if (any_low) begin
              rel_cnt <= '0;
            end else if (rel_cnt == REL_LAST) begin
              rel_cnt <= '0;
              cand    <= '0;
              hit_cnt <= '0;
              row_sel <= row_sel + 4'd1;
              state   <= SETTLE;
            end else begin
              rel_cnt <= rel_cnt + HIT_W'(1);
            end
          end
        end
        default: begin
          state  <= IDLE;
          row_en <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_keypad_row_scanner.sv
// Randomized bench for keypad_row_scanner: a keypad emulation drives col_n from row_sel, and a
// period-level behavioural model predicts row_sel/row_en/key_valid/key_code/multi_key every cycle.
module tb_keypad_row_scanner;

  localparam int NCOLS  = 4;
  localparam int SETTLE = 4;
  localparam int DEB    = 3;
  localparam int CW     = 2;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             scan_en = 1'b0;
  logic             key_ready = 1'b0;
  logic [NCOLS-1:0] col_n = '1;
  logic [3:0]       row_sel;
  logic             row_en;
  logic             key_valid;
  logic [3+CW:0]    key_code;
  logic             multi_key;

  keypad_row_scanner #(
    .NCOLS(NCOLS),
    .SETTLE_CYCLES(SETTLE),
    .DEBOUNCE_SCANS(DEB)
  ) dut (
    .clk(clk),
    .rst(rst),
    .scan_en(scan_en),
    .row_sel(row_sel),
    .row_en(row_en),
    .col_n(col_n),
    .key_valid(key_valid),
    .key_ready(key_ready),
    .key_code(key_code),
    .multi_key(multi_key)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int lowest_low(input logic [NCOLS-1:0] c);
    for (int i = 0; i < NCOLS; i++) if (!c[i]) return i;
    return 0;
  endfunction

  // ---------------- keypad emulation ----------------
  int               kb_mode = 0;  // 0: one key, 1: bounce on row 5, 2: column noise
  logic             key_down = 1'b0;
  logic [3:0]       key_row = '0;
  logic [NCOLS-1:0] key_pat = '1;
  logic [NCOLS-1:0] bounce_pats [5] = '{4'b1110, 4'b1101, 4'b1110, 4'b1110, 4'b1110};
  int               bcyc = 0;

  always @(negedge clk) begin
    if (kb_mode == 2) begin
      col_n = NCOLS'($urandom);
    end else if (kb_mode == 1) begin
      if (row_en && row_sel == 4'd5) begin
        col_n = bounce_pats[(bcyc / 5 > 4) ? 4 : bcyc / 5];
        bcyc++;
      end else begin
        col_n = '1;
        bcyc = 0;
      end
    end else begin
      col_n = (key_down && row_en && row_sel == key_row) ? key_pat : '1;
    end
  end

  // ---------------- behavioural model + per-cycle compare ----------------
  // Tracks the scan in row periods: m_t is the position inside a period (SETTLE is the sample
  // point), m_s is what the scanner sees after its two-stage synchronizer.
  bit               m_on, m_valid, m_release, m_multi;
  logic [3:0]       m_row;
  int               m_t, m_hits, m_col, m_rel, m_c;
  logic [3+CW:0]    m_code;
  logic [NCOLS-1:0] hist0, hist1, m_s;

  always @(posedge clk) begin
    if (rst) begin
      m_on = 0; m_valid = 0; m_release = 0; m_multi = 0;
      m_row = '0; m_t = 0; m_hits = 0; m_col = 0; m_rel = 0; m_code = '0;
      hist0 = '1; hist1 = '1;
    end else begin
      m_s = hist1; hist1 = hist0; hist0 = col_n;
      if (!m_on) begin
        if (scan_en) begin m_on = 1; m_row = '0; m_t = 0; end
      end else if (m_valid) begin
        if (key_ready) begin
          m_valid = 0;
          if (scan_en) begin m_release = 1; m_t = 0; m_rel = 0; end
          else begin m_on = 0; m_release = 0; m_hits = 0; end
        end
      end else if (!scan_en) begin
        m_on = 0; m_release = 0; m_hits = 0; m_t = 0;
      end else if (m_t < SETTLE) begin
        m_t++;
      end else begin
        m_t = 0;
        if (m_release) begin
          if (m_s != '1) m_rel = 0;
          else begin
            m_rel++;
            if (m_rel == DEB) begin m_release = 0; m_hits = 0; m_row++; end
          end
        end else if (m_s == '1) begin
          m_hits = 0;
          m_row++;
        end else begin
          m_c = lowest_low(m_s);
          if (m_hits > 0 && m_c == m_col) m_hits++;
          else begin m_col = m_c; m_hits = 1; end
          if (m_hits == DEB) begin
            m_valid = 1;
            m_code  = {m_row, CW'(m_c)};
            m_multi = ($countones(~m_s) > 1);
          end
        end
      end
    end
    #1;
    chk("row_sel", row_sel, m_row);
    chk("row_en", row_en, m_on);
    chk("key_valid", key_valid, m_valid);
    if (m_valid) begin
      chk("key_code", key_code, m_code);
      chk("multi_key", multi_key, m_multi);
    end
  end

  // ---------------- driver helpers ----------------
  task automatic wait_valid(input int limit, output int n);
    n = 0;
    while (!key_valid && n < limit) begin @(posedge clk); #1; n++; end
    chk("valid_within_bound", key_valid, 1);
  endtask

  task automatic wait_row(input logic [3:0] r, input int limit);
    int n;
    n = 0;
    while (row_sel != r && n < limit) begin @(posedge clk); #1; n++; end
    chk("reach_row", row_sel, r);
  endtask

  task automatic wait_row_change(input int limit);
    int n;
    logic [3:0] r;
    n = 0;
    r = row_sel;
    while (row_sel == r && n < limit) begin @(posedge clk); #1; n++; end
    chk("row_advanced", (row_sel != r), 1);
  endtask

  task automatic accept();
    @(negedge clk); key_ready = 1'b1;
    @(negedge clk); key_ready = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n;
    int cnt;
    logic [3:0] r;

    repeat (3) @(negedge clk);
    chk("rst_row_sel", row_sel, 0);
    chk("rst_row_en", row_en, 0);
    chk("rst_key_valid", key_valid, 0);
    chk("rst_key_code", key_code, 0);
    chk("rst_multi_key", multi_key, 0);
    rst = 1'b0;

    // Free scan with no key: 5 cycles per row, wrap after 80 cycles.
    @(negedge clk); scan_en = 1'b1;
    @(posedge clk);
    repeat (79) @(posedge clk);
    #1 chk("scan_row15", row_sel, 15);
    @(posedge clk);
    #1 chk("scan_wrap", row_sel, 0);
    chk("scan_row_en", row_en, 1);

    // Single key on row 9, column 2.
    key_row = 4'd9; key_pat = 4'b1011; key_down = 1'b1;
    wait_row(4'd9, 200);
    wait_valid(100, n);
    chk("press_latency", n, 15);
    chk("press_code", key_code, 6'b1001_10);
    chk("press_multi", multi_key, 0);

    // Consumer stalls: output held, scan frozen.
    repeat (20) @(posedge clk);
    #1 chk("stall_valid", key_valid, 1);
    chk("stall_row", row_sel, 9);
    chk("stall_code", key_code, 6'b1001_10);
    accept();
    chk("valid_drop", key_valid, 0);

    // Hold the key 10 periods, then release; exactly one report.
    repeat (50) @(negedge clk);
    key_down = 1'b0;
    wait_row_change(100);
    chk("release_row", row_sel, 10);
    cnt = 0;
    repeat (100) begin @(posedge clk); #1; if (key_valid) cnt++; end
    chk("no_second_report", cnt, 0);

    // Two columns low on row 3: lowest column reported, multi flagged.
    @(negedge clk);
    key_row = 4'd3; key_pat = 4'b1010; key_down = 1'b1;
    wait_valid(200, n);
    chk("multi_code", key_code, 6'b0011_00);
    chk("multi_flag", multi_key, 1);
    accept();
    key_down = 1'b0;
    kb_mode = 1;

    // Bounce col 0,1,0,0,0 on row 5: report only after three identical samples.
    wait_row(4'd5, 200);
    wait_valid(100, n);
    chk("bounce_latency", n, 25);
    chk("bounce_code", key_code, 6'b0101_00);
    chk("bounce_multi", multi_key, 0);
    accept();
    kb_mode = 0;

    // scan_en dropped in SETTLE: row_en low on the next edge, row_sel kept.
    wait_row_change(100);
    @(negedge clk);
    r = row_sel;
    scan_en = 1'b0;
    @(posedge clk);
    #1 chk("disable_row_en", row_en, 0);
    chk("disable_row_kept", row_sel, r);
    repeat (5) @(negedge clk);
    scan_en = 1'b1;

    // Random single-key presses with random consumer delay and scan_en gaps.
    for (int it = 0; it < 25; it++) begin
      if ($urandom_range(0, 3) == 0) begin
        @(negedge clk); scan_en = 1'b0;
        repeat ($urandom_range(1, 10)) @(negedge clk);
        scan_en = 1'b1;
      end
      @(negedge clk);
      key_row = 4'($urandom_range(0, 15));
      key_pat = NCOLS'($urandom_range(0, 14));
      key_down = 1'b1;
      wait_valid(300, n);
      chk("rand_code", key_code, {key_row, CW'(lowest_low(key_pat))});
      chk("rand_multi", multi_key, ($countones(~key_pat) > 1));
      repeat ($urandom_range(0, 8)) @(negedge clk);
      accept();
      repeat ($urandom_range(0, 30)) @(negedge clk);
      key_down = 1'b0;
      wait_row_change(100);
      repeat ($urandom_range(0, 10)) @(negedge clk);
    end

    // Column noise with a random consumer, occasional scan_en drops and a mid-run reset.
    kb_mode = 2;
    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      key_ready = 1'($urandom_range(0, 1));
      scan_en = ($urandom_range(0, 49) != 0);
      if (i == 700) rst = 1'b1;
      if (i == 702) rst = 1'b0;
    end
    @(negedge clk);
    kb_mode = 0; key_ready = 1'b0; scan_en = 1'b1; key_down = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;

    // Reset while a key is being reported: outputs return to reset values at once.
    key_row = 4'd2; key_pat = 4'b0111; key_down = 1'b1;
    wait_valid(200, n);
    chk("pre_rst_code", key_code, 6'b0010_11);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("async_rst_valid", key_valid, 0);
    chk("async_rst_row_en", row_en, 0);
    chk("async_rst_row_sel", row_sel, 0);
    chk("async_rst_code", key_code, 0);
    chk("async_rst_multi", multi_key, 0);
    key_down = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (40) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: run exceeded 400000 time units");
    $fatal(1, "watchdog expired");
  end

endmodule
